// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: MIPS funct encodings
// and an operation decoder used by the top level.
package muldiv_unit_pkg;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  function automatic logic is_mul(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU);
  endfunction

  function automatic logic is_div(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply (low bit first) or
// restoring trial-subtract for divide (high bit first).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_addend = i_quo[0] ? i_opnd : {WIDTH{1'b0}};
    w_sum    = {1'b0, i_rem} + {1'b0, w_addend};
    // Partial remainder needs one extra bit before the trial subtract.
    w_shl    = {i_rem, i_quo[WIDTH-1]};
    w_ge     = (w_shl >= {1'b0, i_opnd});
    w_diff   = w_shl[WIDTH-1:0] - i_opnd;
    o_rem    = {1'b0, w_sum[WIDTH-1:1]};
    o_quo    = {w_sum[0], i_quo[WIDTH-1:1]};
    if (i_div) begin
      o_rem = w_ge ? w_diff : w_shl[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], w_ge};
    end else begin
      o_rem = w_sum[WIDTH:1];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit with start/busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: single-pass combinational multiply (divide stays iterative).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER  = WIDTH / STEP;
  localparam int CNT_W = $clog2(ITER + 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0 ||
      WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_param
    $error("muldiv_unit: illegal WIDTH/STEP combination");
  end

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;
  logic [WIDTH-1:0]   r_rem, r_quo, r_opnd;
  logic               r_is_div, r_neg_q, r_neg_r, r_div0;

  logic               w_accept, w_is_mul, w_is_div, w_sa, w_sb;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_prod, w_mres;
  logic [WIDTH-1:0]   w_qres, w_rres, w_fix_hi, w_fix_lo;
  logic [WIDTH-1:0]   w_rem_ch [STEP+1];
  logic [WIDTH-1:0]   w_quo_ch [STEP+1];

  always_comb begin
    w_is_mul    = is_mul(funct);
    w_is_div    = is_div(funct);
    w_accept    = start && (r_state == IDLE);
    w_sa        = is_signed_op(funct) && rdata1[WIDTH-1];
    w_sb        = is_signed_op(funct) && rdata2[WIDTH-1];
    w_mag_a     = mag(rdata1, w_sa);
    w_mag_b     = mag(rdata2, w_sb);
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && (w_is_mul || w_is_div))
              w_state_nxt = (w_is_mul && FAST_MUL) ? FIX : CALC;
      CALC: if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = FIX;
      FIX:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rem_ch[0] = r_rem;
  assign w_quo_ch[0] = r_quo;
  for (genvar g = 0; g < STEP; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_div  (r_is_div),
      .i_rem  (w_rem_ch[g]),
      .i_quo  (w_quo_ch[g]),
      .i_opnd (r_opnd),
      .o_rem  (w_rem_ch[g+1]),
      .o_quo  (w_quo_ch[g+1])
    );
  end

  // Sign fixup and HI/LO selection applied in FIX.
  always_comb begin
    w_prod = {r_rem, r_quo};
`ifdef MULDIV_FAST_MUL_EN
    if (!r_is_div) w_prod = {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_quo};
`endif
    w_mres   = r_neg_q ? -w_prod : w_prod;
    w_qres   = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_quo : r_quo);
    w_rres   = r_neg_r ? -r_rem : r_rem;
    w_fix_hi = r_is_div ? w_rres : w_mres[2*WIDTH-1:WIDTH];
    w_fix_lo = r_is_div ? w_qres : w_mres[WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == FIX);
      r_cnt   <= (r_state == CALC) ? r_cnt + 1'b1 : '0;
      if (r_state == FIX) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_accept && funct == FN_MTHI) begin
        r_hi <= rdata1;
      end else if (w_accept && funct == FN_MTLO) begin
        r_lo <= rdata1;
      end
    end
  end

  // Multiply: r_quo = multiplier, r_opnd = multiplicand. Divide: r_quo = dividend, r_opnd = divisor.
  always_ff @(posedge CLK) begin
    if (w_accept && (w_is_mul || w_is_div)) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_div0   <= (rdata2 == '0);
      r_rem    <= '0;
      r_quo    <= w_is_div ? w_mag_a : w_mag_b;
      r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
    end else if (r_state == CALC) begin
      r_rem <= w_rem_ch[STEP];
      r_quo <= w_quo_ch[STEP];
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with a queue scoreboard checking
// HI/LO and done timing whenever the DUT pulses done.
module tb_muldiv_unit;

  localparam logic [5:0] F_MTHI = 6'h11, F_MTLO = 6'h13, F_MULT = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam int LAT_DIV = 34;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL  = 2;
  localparam int BUSY_MUL = 1;
`else
  localparam int LAT_MUL  = 34;
  localparam int BUSY_MUL = 33;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'h0;
  logic [31:0] rdata1 = '0, rdata2 = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32), .STEP(1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .funct(funct),
    .rdata1(rdata1), .rdata2(rdata2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        check({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; presents the request for exactly one accepting edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string nm, input bit push, input logic [31:0] eh,
                       input logic [31:0] el, input int lat);
    exp_t e;
    start = 1'b1; funct = f; rdata1 = a; rdata2 = b;
    if (push) begin
      e.name = nm; e.hi = eh; e.lo = el; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge CLK);
    start = 1'b0; funct = 6'($urandom); rdata1 = $urandom; rdata2 = $urandom;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check({nm, "_idle_timeout"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    issue(6'h00, 32'hAAAA_5555, 32'h1, "unk", 1'b0, 32'h0, 32'h0, 0);
    check("unk_busy", 64'(busy), 64'd0);
    check("unk_hi", 64'(hi), 64'd0);

    issue(F_MTHI, 32'h0000_1234, 32'h0, "mthi", 1'b0, 32'h0, 32'h0, 0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(F_MTLO, 32'h0000_5678, 32'h0, "mtlo", 1'b0, 32'h0, 32'h0, 0);
    check("mtlo_lo", 64'(lo), 64'h5678);
    check("mtlo_done", 64'(done), 64'd0);

    // MTLO during a divide must be dropped; HI/LO hold until FIX.
    issue(F_DIV, 32'd1000, 32'hFFFF_FFFD, "div_1000_m3", 1'b1, 32'h1, 32'hFFFF_FEB3, LAT_DIV);
    repeat (5) @(negedge CLK);
    issue(F_MTLO, 32'h0000_DEAD, 32'h0, "mtlo_busy", 1'b0, 32'h0, 32'h0, 0);
    check("busy_mid_div", 64'(busy), 64'd1);
    check("mid_div_lo", 64'(lo), 64'h5678);
    check("mid_div_hi", 64'(hi), 64'h1234);
    wait_idle("div_1000_m3");

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1, 32'hFFFF_FFFE, 32'h1, LAT_MUL);
    n = 1;
    while (busy && n < 100) begin
      @(negedge CLK);
      if (busy) n++;
    end
    check("multu_busy_cycles", 64'(n), 64'(BUSY_MUL));
    wait_idle("multu_max");

    issue(F_MULT, 32'hFFFF_FFFD, 32'd7, "mult_m3x7", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_MUL);
    wait_idle("mult_m3x7");
    issue(F_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minxmin", 1'b1, 32'h4000_0000, 32'h0, LAT_MUL);
    wait_idle("mult_minxmin");

    // Back-to-back: a new start in the done cycle is accepted.
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
    n = 0;
    while (!done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_done_seen", 64'(done), 64'd1);
    issue(F_DIVU, 32'd7, 32'd2, "divu_7_2", 1'b1, 32'h1, 32'h3, LAT_DIV);
    check("b2b_accept_busy", 64'(busy), 64'd1);
    wait_idle("divu_7_2");

    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 1'b1, 32'h0, 32'h8000_0000, LAT_DIV);
    wait_idle("div_min_m1");
    issue(F_DIVU, 32'd5, 32'd0, "divu_5_0", 1'b1, 32'h5, 32'hFFFF_FFFF, LAT_DIV);
    wait_idle("divu_5_0");
    issue(F_DIV, 32'hFFFF_FFFB, 32'd0, "div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, LAT_DIV);
    wait_idle("div_m5_0");

    // Reset in the middle of an iterative multiply aborts it silently.
`ifdef MULDIV_FAST_MUL_EN
    issue(F_MULT, 32'd1234, 32'hFFFF_FFFB, "mult_rst", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_E7E6, LAT_MUL);
`else
    issue(F_MULT, 32'd1234, 32'hFFFF_FFFB, "mult_rst", 1'b0, 32'h0, 32'h0, 0);
`endif
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge CLK);

    issue(F_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b1, 32'h2, 32'd14, LAT_DIV);
    wait_idle("divu_100_7");
    repeat (2) @(negedge CLK);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair for the EX stage.
- Replaces single-cycle `*` and `/` arithmetic with an iterative shift-add multiplier and a restoring divider.
- Retires STEP bits per cycle and exposes a start/busy/done handshake so the core can stall MFHI/MFLO until results are ready.
- Fixes division semantics to the architectural convention: LO = quotient, HI = remainder.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits. Must be even and >= 4.
- STEP, 1: bits retired per iteration cycle. Legal values are 1, 2, 4. WIDTH % STEP == 0, checked at elaboration.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- start  in  1  request strobe, sampled on CLK rising edge
- funct  in  6  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (common_param.vh encodings)
- rdata1  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- rdata2  in  WIDTH  rt operand (divisor / multiplier)
- busy  out  WIDTH-independent 1  operation in flight; start ignored while high
- done  out  1  one-cycle pulse; HI/LO hold new result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, RST high at CLK edge): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. RST overrides start and any in-flight operation.
- States:
  - IDLE -> CALC on accepted MULT/MULTU/DIV/DIVU.
  - CALC -> CALC for ITER=WIDTH/STEP edges.
  - CALC -> FIX after the final iteration.
  - FIX -> IDLE.
- busy = (state != IDLE).
- Accept rule: start sampled high at edge k while state==IDLE.
  - MTHI/MTLO: hi (resp. lo) <= rdata1 at edge k. No busy, no done.
  - MULT/MULTU/DIV/DIVU:
    - Edge k: latch operand magnitudes (absolute value for signed ops) and result-sign bits.
    - Edges k+1..k+ITER: iterate.
    - Edge k+ITER+1 (FIX): apply sign fixup and write hi/lo.
    - done=1 during the cycle after edge k+ITER+1, busy=0 in that same cycle.
    - WIDTH=32, STEP=1: busy high for 33 cycles.
  - Unknown funct with start: ignored.
- start while busy: ignored, including MTHI/MTLO. hi/lo unchanged until FIX.
- start in the cycle done is high: accepted (state is IDLE).
- Multiply: full 2*WIDTH product, {hi,lo}. Signed product is negated in FIX when operand signs differ.
- Divide (truncate toward zero):
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Boundaries:
  - Divisor 0: lo = all ones, hi = rdata1 as latched (signed and unsigned). Same latency.
  - Signed MIN / -1: lo = MIN, hi = 0 (natural wrap, no trap).
  - MIN magnitude: held in a WIDTH-bit unsigned register. No WIDTH+1 extension needed except in the divider partial remainder (WIDTH+1 bits).
- Operand inputs need only be valid in the accepting cycle; they are latched internally.
- hi/lo change only on reset, MTHI/MTLO accept, or FIX.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the product combinationally from latched operands.
  - Skip CALC: IDLE -> FIX at edge k; hi/lo written at edge k+1.
  - busy high for 1 cycle, done in the cycle after edge k+1.
  - Division is unchanged.
- Undefined: all four ops are iterative as above. No `*` operator appears in the RTL.

Decomposition:
- Funct encodings (MULT 6'h18, MULTU 6'h19, DIV 6'h1a, DIVU 6'h1b, MTHI 6'h11, MTLO 6'h13) stay in common_param.vh.
- State encoding (IDLE, CALC, FIX) is a localparam in the module.
- One sub-module, muldiv_step: combinational single-bit iteration (conditional add+shift for multiply, trial subtract+shift for divide). Instantiated STEP times in a generate chain.

Test Plan (WIDTH=32, STEP=1, macro undefined unless stated):
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after accept; busy high 33 cycles.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same op with MULDIV_FAST_MUL_EN -> identical result, done 2 edges after accept.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0xFFFFFFFB/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- MTHI 0x1234 while idle -> hi=0x1234 next edge, busy/done stay 0. MTLO issued mid-DIV -> ignored, final lo = quotient. New start in the done cycle -> accepted.
- RST asserted at iteration 10 of MULT -> next edge busy=0, hi=lo=0, no done pulse. Fresh DIVU 100/7 afterwards -> lo=14, hi=2.
